// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter for a single-port synchronous data memory: grant one cycle after req, rvalid one cycle after a read grant.
// Backpressure: a losing requester holds req until granted; the same port is never granted in consecutive cycles.
module dmem_arbiter #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req0,
   input  logic              req1,
   input  logic              we0,
   input  logic              we1,
   input  logic [ADDR_W-1:0] addr0,
   input  logic [ADDR_W-1:0] addr1,
   input  logic [DATA_W-1:0] wdata0,
   input  logic [DATA_W-1:0] wdata1,
   output logic              gnt0,
   output logic              gnt1,
   output logic              rvalid0,
   output logic              rvalid1,
   output logic [DATA_W-1:0] rdata0,
   output logic [DATA_W-1:0] rdata1,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t            state, state_nxt;
   logic              cur;          // port owning the current ACCESS cycle
   logic              last_served;
   logic              take;
   logic              pick;
   logic              lat_we;
   logic [ADDR_W-1:0] lat_addr;
   logic [DATA_W-1:0] lat_wdata;
   logic [DATA_W-1:0] rdata0_q;
   logic [DATA_W-1:0] rdata1_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // The winner's own req is ignored in ACCESS, so a port can never win twice in a row.
   always_comb begin
      state_nxt = state;
      take      = 1'b0;
      pick      = cur;
      case (state)
         IDLE: begin
            if (req0 || req1) begin
               take      = 1'b1;
               pick      = (req0 && req1) ? ~last_served : req1;
               state_nxt = ACCESS;
            end
         end
         ACCESS: begin
            if (cur ? req0 : req1) begin
               take      = 1'b1;
               pick      = ~cur;
               state_nxt = ACCESS;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cur         <= 1'b0;
         last_served <= 1'b1;
         lat_we      <= 1'b0;
         lat_addr    <= '0;
         lat_wdata   <= '0;
         rvalid0     <= 1'b0;
         rvalid1     <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
      end else begin
         if (take) begin
            cur       <= pick;
            lat_we    <= pick ? we1 : we0;
            lat_addr  <= pick ? addr1 : addr0;
            lat_wdata <= pick ? wdata1 : wdata0;
         end
         if (state == ACCESS) last_served <= cur;
         rvalid0 <= (state == ACCESS) && !lat_we && !cur;
         rvalid1 <= (state == ACCESS) && !lat_we && cur;
         if (rvalid0) rdata0_q <= mem_rdata;
         if (rvalid1) rdata1_q <= mem_rdata;
      end
   end

   // Memory data arrives the cycle after the grant; the holding regs keep it once rvalid drops.
   always_comb begin
      mem_en    = (state == ACCESS);
      mem_we    = (state == ACCESS) && lat_we;
      gnt0      = (state == ACCESS) && !cur;
      gnt1      = (state == ACCESS) && cur;
      mem_addr  = lat_addr;
      mem_wdata = lat_wdata;
      rdata0    = rvalid0 ? mem_rdata : rdata0_q;
      rdata1    = rvalid1 ? mem_rdata : rdata1_q;
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a synchronous 32-word memory model attached.
module tb_dmem_arbiter;
   localparam int ADDR_W = 5;
   localparam int DATA_W = 8;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
   logic [ADDR_W-1:0] addr0 = '0, addr1 = '0;
   logic [DATA_W-1:0] wdata0 = '0, wdata1 = '0;
   logic              gnt0, gnt1, rvalid0, rvalid1, mem_en, mem_we;
   logic [DATA_W-1:0] rdata0, rdata1, mem_wdata;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_rdata = '0;
   logic [DATA_W-1:0] mem [32];

   int checks = 0;
   int errors = 0;

   dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
      .clock(clock), .reset(reset),
      .req0(req0), .req1(req1), .we0(we0), .we1(we1),
      .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
      .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
      .rdata0(rdata0), .rdata1(rdata1),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata <= mem[mem_addr];
      end
   end

   // Advance to just after the next rising edge; outputs are checked and inputs driven there.
   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
      reset = 1'b1;
      tick(); tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick(); tick();
      checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL reset_gnt: got %b%b want 00", gnt0, gnt1); end
      checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b%b want 00", rvalid0, rvalid1); end
      checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_en_we: got %b%b want 00", mem_en, mem_we); end
      checks++; if (mem_addr !== 5'd0 || mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_bus: got %h/%h want 00/00", mem_addr, mem_wdata); end
      checks++; if (rdata0 !== 8'h00 || rdata1 !== 8'h00) begin errors++; $display("FAIL reset_rdata: got %h/%h want 00/00", rdata0, rdata1); end
      reset = 1'b0;
   endtask

   task automatic test_single_read();
      req0 = 1'b1; we0 = 1'b0; addr0 = 5'd5;
      tick();
      checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin errors++; $display("FAIL rd_gnt: got %b%b want gnt0=1 gnt1=0", gnt0, gnt1); end
      checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 5'd5) begin errors++; $display("FAIL rd_mem: got en=%b we=%b addr=%0d want 1 0 5", mem_en, mem_we, mem_addr); end
      req0 = 1'b0;
      tick();
      checks++; if (rvalid0 !== 1'b1 || rdata0 !== 8'h05) begin errors++; $display("FAIL rd_rvalid: got rvalid0=%b rdata0=%h want 1 05", rvalid0, rdata0); end
      checks++; if (gnt0 !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL rd_idle: got gnt0=%b mem_en=%b want 0 0", gnt0, mem_en); end
      tick();
      checks++; if (rvalid0 !== 1'b0 || rdata0 !== 8'h05) begin errors++; $display("FAIL rd_hold: got rvalid0=%b rdata0=%h want 0 05", rvalid0, rdata0); end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3;
      req1 = 1'b1; we1 = 1'b0; addr1 = 5'd17;
      tick();
      checks++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || mem_addr !== 5'd3) begin errors++; $display("FAIL tie_first: got gnt=%b%b addr=%0d want gnt0 addr 3", gnt1, gnt0, mem_addr); end
      req0 = 1'b0;
      tick();
      checks++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || mem_addr !== 5'd17) begin errors++; $display("FAIL tie_second: got gnt=%b%b addr=%0d want gnt1 addr 17", gnt1, gnt0, mem_addr); end
      checks++; if (rvalid0 !== 1'b1 || rdata0 !== 8'h03) begin errors++; $display("FAIL tie_rdata0: got %b/%h want 1/03", rvalid0, rdata0); end
      req1 = 1'b0;
      tick();
      checks++; if (rvalid1 !== 1'b1 || rdata1 !== 8'hFF || rvalid0 !== 1'b0) begin errors++; $display("FAIL tie_rdata1: got rvalid1=%b rdata1=%h rvalid0=%b want 1 ff 0", rvalid1, rdata1, rvalid0); end
      checks++; if (gnt0 !== 1'b0 || gnt1 !== 1'b0) begin errors++; $display("FAIL tie_done: got gnt=%b%b want 00", gnt1, gnt0); end
   endtask

   task automatic test_round_robin();
      int grants = 0;
      int expect_port = 0;
      apply_reset();
      req0 = 1'b1; we0 = 1'b0; addr0 = 5'd1;
      req1 = 1'b1; we1 = 1'b0; addr1 = 5'd2;
      for (int cyc = 0; cyc < 40 && grants < 8; cyc++) begin
         tick();
         if (gnt0 || gnt1) begin
            checks++;
            if ((gnt0 && gnt1) || (gnt1 !== expect_port[0])) begin
               errors++; $display("FAIL rr_grant%0d: got gnt=%b%b want port %0d", grants, gnt1, gnt0, expect_port);
            end
            grants++;
            expect_port = 1 - expect_port;
         end
         req0 = !gnt0;
         req1 = !gnt1;
      end
      checks++; if (grants !== 8) begin errors++; $display("FAIL rr_count: got %0d grants want 8 within budget", grants); end
      req0 = 1'b0; req1 = 1'b0;
      tick(); tick();
   endtask

   task automatic test_write();
      req1 = 1'b1; we1 = 1'b1; addr1 = 5'd10; wdata1 = 8'h5A;
      tick();
      checks++; if (gnt1 !== 1'b1 || mem_en !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL wr_strobe: got gnt1=%b en=%b we=%b want 1 1 1", gnt1, mem_en, mem_we); end
      checks++; if (mem_addr !== 5'd10 || mem_wdata !== 8'h5A) begin errors++; $display("FAIL wr_bus: got addr=%0d wdata=%h want 10 5a", mem_addr, mem_wdata); end
      req1 = 1'b0; we1 = 1'b0;
      tick();
      checks++; if (rvalid1 !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL wr_no_rvalid: got rvalid1=%b mem_en=%b want 0 0", rvalid1, mem_en); end
      req0 = 1'b1; we0 = 1'b0; addr0 = 5'd10;
      tick();
      checks++; if (gnt0 !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 5'd10) begin errors++; $display("FAIL wr_readback_gnt: got gnt0=%b we=%b addr=%0d want 1 0 10", gnt0, mem_we, mem_addr); end
      req0 = 1'b0;
      tick();
      checks++; if (rvalid0 !== 1'b1 || rdata0 !== 8'h5A || rvalid1 !== 1'b0) begin errors++; $display("FAIL wr_readback: got rvalid0=%b rdata0=%h rvalid1=%b want 1 5a 0", rvalid0, rdata0, rvalid1); end
   endtask

   task automatic test_reset_abort();
      req0 = 1'b1; we0 = 1'b0; addr0 = 5'd7;
      tick();
      checks++; if (gnt0 !== 1'b1 || mem_addr !== 5'd7) begin errors++; $display("FAIL abort_gnt: got gnt0=%b addr=%0d want 1 7", gnt0, mem_addr); end
      reset = 1'b1;
      req0 = 1'b0;
      #1;
      checks++; if (gnt0 !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL abort_async: got gnt0=%b mem_en=%b want 0 0", gnt0, mem_en); end
      tick();
      checks++; if (rvalid0 !== 1'b0 || mem_addr !== 5'd0 || rdata0 !== 8'h00 || rdata1 !== 8'h00) begin errors++; $display("FAIL abort_outputs: got rvalid0=%b addr=%0d rdata=%h/%h want 0 0 00/00", rvalid0, mem_addr, rdata0, rdata1); end
      reset = 1'b0;
      tick();
      checks++; if (rvalid0 !== 1'b0 || gnt0 !== 1'b0 || mem_en !== 1'b0) begin errors++; $display("FAIL abort_after1: got rvalid0=%b gnt0=%b en=%b want 0 0 0", rvalid0, gnt0, mem_en); end
      tick();
      checks++; if (rvalid0 !== 1'b0 || rvalid1 !== 1'b0 || gnt0 !== 1'b0) begin errors++; $display("FAIL abort_after2: got rvalid=%b%b gnt0=%b want 00 0", rvalid1, rvalid0, gnt0); end
      req0 = 1'b1; we0 = 1'b0; addr0 = 5'd4;
      tick();
      checks++; if (gnt0 !== 1'b1 || mem_addr !== 5'd4) begin errors++; $display("FAIL abort_next_gnt: got gnt0=%b addr=%0d want 1 4", gnt0, mem_addr); end
      req0 = 1'b0;
      tick();
      checks++; if (rvalid0 !== 1'b1 || rdata0 !== 8'h04) begin errors++; $display("FAIL abort_next_rdata: got %b/%h want 1/04", rvalid0, rdata0); end
   endtask

   initial begin
      for (int i = 0; i < 32; i++) mem[i] = 8'(i);
      mem[17] = 8'hFF;
      test_reset();
      test_single_read();
      test_back_to_back();
      test_round_robin();
      test_write();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 5, data-memory address width (32 words).
REQ-002 SHALL have parameter DATA_W, default 8, data word width.
REQ-003 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports req0/req1  input  1  access request from the CPU (port 0) and the debug/console port (port 1).
REQ-006 SHALL have ports we0/we1  input  1  1 = write, 0 = read.
REQ-007 SHALL have ports addr0/addr1  input  ADDR_W  word address.
REQ-008 SHALL have ports wdata0/wdata1  input  DATA_W  write data.
REQ-009 SHALL have ports gnt0/gnt1  output  1  one-cycle grant; the access is performed in that cycle.
REQ-010 SHALL have ports rvalid0/rvalid1  output  1  one-cycle read-data-valid strobe.
REQ-011 SHALL have ports rdata0/rdata1  output  DATA_W  read data, meaningful only while the matching rvalid is high.
REQ-012 SHALL have ports mem_en, mem_we  output  1  memory strobe and write enable.
REQ-013 SHALL have port mem_addr  output  ADDR_W  memory address.
REQ-014 SHALL have port mem_wdata  output  DATA_W  memory write data.
REQ-015 SHALL have port mem_rdata  input  DATA_W  synchronous memory read data, valid the cycle after mem_en with mem_we=0.

Function
REQ-016 SHALL implement FSM states IDLE and ACCESS.
REQ-017 In IDLE with any req high, SHALL latch the winner's we/addr/wdata and move to ACCESS; with no req, SHALL stay in IDLE.
REQ-018 In ACCESS, SHALL assert mem_en=1, gnt_w=1 (winner only), and drive mem_we/mem_addr/mem_wdata from the latched copy; all are registered, with no combinational path from req to mem_*.
REQ-019 Outside ACCESS, SHALL hold mem_en=0, mem_we=0, gnt0=gnt1=0.
REQ-020 Arbitration: single req wins; with both high, the port not served last SHALL win (round-robin); the last_served pointer SHALL update on each grant.
REQ-021 In ACCESS, SHALL ignore the current winner's req and SHALL go to ACCESS again with the other port if its req is high, else to IDLE. Back-to-back alternating grants are allowed; the same port is never granted in consecutive cycles.
REQ-022 For a read grant in cycle N, rvalid_w SHALL be 1 in cycle N+1 with rdata_w=mem_rdata; rvalid SHALL never be asserted for writes.
REQ-023 Requester contract: req/we/addr/wdata stay stable from req rise until the cycle after gnt, and req drops the cycle after gnt. The arbiter SHALL NOT depend on req dropping beyond REQ-021.
REQ-024 Address arithmetic is performed by requesters; the arbiter SHALL pass addr unmodified (no wrap or offset).
REQ-025 rdata0/rdata1 SHALL hold their last value when rvalid is low.

Reset
REQ-026 On reset, SHALL enter IDLE with gnt0=gnt1=0, rvalid0=rvalid1=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, rdata0=rdata1=0, and last_served=1, so port 0 wins the first tie.
REQ-027 Reset asserted mid-ACCESS or with a read return pending SHALL abort the access; no gnt or rvalid SHALL be produced after reset deasserts.

Verification
REQ-028 Reset, then req0=1, we0=0, addr0=5 with memory word 5=0x05 -> gnt0 one cycle later with mem_addr=5; rvalid0=1, rdata0=0x05 the next cycle.
REQ-029 req0 and req1 rise together as reads (addr 3, addr 17=0xFF) -> gnt0 first, gnt1 the next cycle; rdata0=0x03, rdata1=0xFF on consecutive rvalids.
REQ-030 Both ports request continuously (re-raising after each grant) -> grants strictly alternate 0,1,0,1 for 8 grants; no port starves.
REQ-031 req1 write we1=1, addr1=10, wdata1=0x5A -> mem_en=mem_we=1, mem_addr=10, mem_wdata=0x5A in the gnt1 cycle, no rvalid1; a later read of 10 by port 0 -> rdata0=0x5A.
REQ-032 Reset asserted during ACCESS of a read -> no rvalid afterward, all outputs 0; the next req0 is served normally.
